rv_fetch_stage: RTL and testbench

Instruction-fetch (IF) stage for riscv_pipeline; sits directly upstream of decode.
- Owns the fetch PC and issues word reads to a synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions in a small FIFO so decode stalls never lose an in-flight word.
- Handles redirects (branch/jump) from EX by flushing the buffer and discarding stale responses.

---
 rtl/rvp_fetch_pkg.sv | 13 +
 rtl/rvp_fetch_fifo.sv | 48 ++++
 rtl/rv_fetch_stage.sv | 125 ++++++++++++
 tb/tb_rv_fetch_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/rvp_fetch_pkg.sv
// rvp_fetch_pkg: shared types and constants for the rv_fetch_stage instruction-fetch block.
package rvp_fetch_pkg;
    localparam int RVP_XLEN = 32;
    localparam logic [RVP_XLEN-1:0] RVP_NOP_INSTR = 32'h0000_0013;

    typedef enum logic {BOOT, RUN} fetch_state_e;

    typedef struct packed {
        logic [RVP_XLEN-1:0] instr;
        logic [RVP_XLEN-1:0] pc;
        logic                fault;
    } fetch_entry_t;
endpackage

// File: rtl/rvp_fetch_fifo.sv
// rvp_fetch_fifo: DEPTH-entry instruction buffer; flush empties it, push+pop allowed when full.
module rvp_fetch_fifo
    import rvp_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);
    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_pop;

    assign do_pop = pop && !empty;
    assign rdata  = mem_q[rd_q];
    assign count  = cnt_q;
    assign full   = cnt_q == (AW+1)'(DEPTH);
    assign empty  = cnt_q == '0;

    always_ff @(posedge clk)
        if (push && !flush) mem_q[wr_q] <= wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/rv_fetch_stage.sv
// rv_fetch_stage: IF stage owning the fetch PC, 1-cycle imem reads and a redirect-flushed buffer.
// RVP_FETCH_MISALIGN_EN: misaligned redirects push one fault entry and hold fetch until redirected.
module rv_fetch_stage
    import rvp_fetch_pkg::*;
#(
    parameter int              XLEN      = RVP_XLEN,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = RVP_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_init,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_fault,
    output logic [XLEN-1:0] pc_out
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, tag_q, tag_d;
    logic            inflight_q, inflight_d;
    logic            pop, push, flush, halt, full, empty;
    logic [CW-1:0]   count;
    logic [CW:0]     occ;
    fetch_entry_t    wdata, head;

    assign pop       = if_valid && if_ready;
    assign flush     = redirect && state_q == RUN;
    // buffered + in-flight words after this cycle's pop must leave room for one more
    assign occ       = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign imem_req  = state_q == RUN && !redirect && !halt && occ < (CW+1)'(DEPTH);
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign if_valid  = !empty;
    assign if_instr  = empty ? NOP_INSTR : head.instr;
    assign if_pc     = empty ? '0 : head.pc;
    assign if_fault  = !empty && head.fault;

    always_comb begin
        state_d    = RUN;
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        if (state_q == BOOT) pc_d = pc_init & ~XLEN'(3);
        else if (redirect) pc_d = redirect_pc & ~XLEN'(3);
        else if (imem_req) begin
            pc_d       = pc_q + XLEN'(4);
            tag_d      = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= '0;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef RVP_FETCH_MISALIGN_EN
    logic            halt_q, halt_d, fault_q, fault_d;
    logic [XLEN-1:0] fpc_q, fpc_d;

    always_comb begin
        halt_d  = halt_q;
        fault_d = 1'b0;
        fpc_d   = fpc_q;
        if (flush) begin
            halt_d  = redirect_pc[1:0] != 2'b00;
            fault_d = halt_d;
            fpc_d   = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_q  <= 1'b0;
            fault_q <= 1'b0;
            fpc_q   <= '0;
        end else begin
            halt_q  <= halt_d;
            fault_q <= fault_d;
            fpc_q   <= fpc_d;
        end
    end

    assign halt  = halt_q;
    assign push  = (inflight_q || fault_q) && !flush;
    assign wdata = fault_q ? '{NOP_INSTR, fpc_q, 1'b1} : '{imem_rdata, tag_q, 1'b0};
`else
    assign halt  = 1'b0;
    assign push  = inflight_q && !flush;
    assign wdata = '{imem_rdata, tag_q, 1'b0};
`endif

    rvp_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop));
endmodule

// File: tb/tb_rv_fetch_stage.sv
// tb_rv_fetch_stage: random decode stalls, redirects and resets against a PC-stream model.
module tb_rv_fetch_stage;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, redirect, if_ready, imem_req, if_valid, if_fault;
    logic [31:0] pc_init, imem_addr, imem_rdata, redirect_pc, if_instr, if_pc, pc_out;

    int          n_tests = 0, n_fail = 0;
    logic [31:0] exp_req, exp_pop, fault_pc;
    int          outstanding, since;
    bit          in_reset, halted, mis_pending;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem_req ? imem_addr + 32'h1000 : 32'hDEAD_BEEF;

    rv_fetch_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_init     (pc_init),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_fault    (if_fault),
        .pc_out      (pc_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // one clock cycle: drive inputs after the falling edge, check, then advance the model
    task automatic step(input bit rn, input bit rdy, input bit rd, input logic [31:0] rpc);
        bit boot, ev;
        @(negedge clk);
        reset       = rn;
        if_ready    = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        if (!rn) begin
            check("rst_req", imem_req, 0);
            check("rst_valid", if_valid, 0);
            check("rst_fault", if_fault, 0);
            check("rst_instr", if_instr, 32'h0000_0013);
            check("rst_if_pc", if_pc, 0);
            check("rst_pc_out", pc_out, 0);
            in_reset = 1;
            since    = 0;
            return;
        end
        boot     = in_reset;
        in_reset = 0;
        ev       = boot || rd;
        if (ev) check("no_req", imem_req, 0);
        if (!boot) check("pc_out", pc_out, exp_req);
        if (halted) begin
            check("halt_req", imem_req, 0);
            if (!mis_pending) check("halt_valid", if_valid, 0);
        end else if (since < 3) check("bubble", if_valid, 0);
        else check("valid", if_valid, 1);
        if (imem_req) begin
            check("addr", imem_addr, exp_req);
            exp_req += 4;
            outstanding++;
        end
        if (if_valid && if_ready) begin
            if (mis_pending) begin
                check("flt_fault", if_fault, 1);
                check("flt_instr", if_instr, 32'h0000_0013);
                check("flt_pc", if_pc, fault_pc);
                mis_pending = 0;
            end else begin
                check("if_pc", if_pc, exp_pop);
                check("if_instr", if_instr, exp_pop + 32'h1000);
                check("if_fault", if_fault, 0);
                exp_pop += 4;
                outstanding--;
            end
        end
        check("occupancy", outstanding <= DEPTH, 1);
        if (boot) begin
            exp_req     = pc_init;
            exp_pop     = pc_init;
            outstanding = 0;
            halted      = 0;
            mis_pending = 0;
        end else if (rd) begin
            exp_req     = rpc & ~32'h3;
            exp_pop     = exp_req;
            outstanding = 0;
            halted      = 0;
            mis_pending = 0;
`ifdef RVP_FETCH_MISALIGN_EN
            if (rpc[1:0] != 2'b00) begin
                halted      = 1;
                mis_pending = 1;
                fault_pc    = rpc;
            end
`endif
        end
        since = ev ? 1 : since + 1;
    endtask

    initial begin
        reset = 1'b0; if_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        pc_init = 32'h40; in_reset = 1; halted = 0; mis_pending = 0;
        exp_req = '0; exp_pop = '0; fault_pc = '0; outstanding = 0; since = 0;
        repeat (5) step(0, 1, 0, 0);
        repeat (12) step(1, 1, 0, 0);
        repeat (4) step(1, 0, 0, 0);
        repeat (8) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h100);
        repeat (8) step(1, 1, 0, 0);
        step(1, 1, 1, 32'h200);
        repeat (8) step(1, 1, 0, 0);
        pc_init = 32'hFFFF_FFF8;
        repeat (2) step(0, 1, 0, 0);
        repeat (8) step(1, 1, 0, 0);
        step(1, 1, 1, 32'h102);
        repeat (8) step(1, 1, 0, 0);
        step(1, 1, 1, 32'h300);
        repeat (8) step(1, 1, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit          rn, rdy, rd;
            logic [31:0] rpc;
            rn  = $urandom_range(0, 199) != 0;
            rdy = $urandom_range(0, 3) != 0;
            rd  = $urandom_range(0, 11) == 0;
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if (!rn) pc_init = $urandom & ~32'h3;
            step(rn, rdy, rd, rpc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
